fm_rx: RTL and testbench

FM_RX -- requirements
Module: fm_rx

---
 rtl/fm_pkg.sv | 6 +
 rtl/fm_rx_edge.sv | 24 ++
 rtl/fm_rx.sv | 64 ++++++
 tb/tb_fm_rx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fm_pkg.sv
// fm_pkg: state encoding and default counter width shared by fm_tx and fm_rx
package fm_pkg;
    localparam int CNT_SZ_DEF = 16;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MEAS = 1'b1;
endpackage

// File: rtl/fm_rx_edge.sv
// fm_rx_edge: two-flop synchroniser followed by a registered rising-edge flag
module fm_rx_edge (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_in,
    output logic o_rise
);
    logic r_s1, r_s2, r_s3, r_rise;
    // synchronise i_in, keep the previous synchronised value, flag a 0->1 step
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_s1   <= i_in;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_rise <= r_s2 & ~r_s3;
        end
    end
    assign o_rise = r_rise;
endmodule

// File: rtl/fm_rx.sv
// fm_rx: FM period-measuring receiver; rising-edge spacing decides each bit
module fm_rx
    import fm_pkg::*;
#(
    parameter int p_cnt_sz = CNT_SZ_DEF
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic                i_fm,
    input  logic [p_cnt_sz-1:0] i_thresh,
    input  logic [p_cnt_sz-1:0] i_timeout,
    input  logic                i_clr,
    output logic [p_cnt_sz-1:0] o_period,
    output logic                o_bit,
    output logic                o_valid,
    output logic                o_lock
);
    localparam logic [p_cnt_sz-1:0] c_one = p_cnt_sz'(1);
    logic [0:0]          r_state;
    logic [p_cnt_sz-1:0] r_cnt, r_period;
    logic                r_bit, r_valid, r_lock;
    logic                w_rise, w_sat, w_tmo;
    fm_rx_edge u_edge (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_in   (i_fm),
        .o_rise (w_rise)
    );
    assign w_sat = &r_cnt;
    assign w_tmo = (i_timeout != '0) && (r_cnt == i_timeout);
    // measurement FSM: clear beats edge, edge beats timeout, counter saturates
    always_ff @(posedge i_clk) begin
        if (!i_nrst || i_clr) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_bit    <= 1'b0;
            r_valid  <= 1'b0;
            r_lock   <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_valid <= 1'b0;
            r_state <= w_rise ? ST_MEAS : ST_IDLE;
            r_cnt   <= w_rise ? c_one : '0;
        end else if (w_rise) begin
            r_period <= r_cnt;
            r_bit    <= r_cnt < i_thresh;
            r_valid  <= 1'b1;
            r_lock   <= 1'b1;
            r_cnt    <= c_one;
        end else if (w_tmo) begin
            r_state <= ST_IDLE;
            r_lock  <= 1'b0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_cnt   <= w_sat ? r_cnt : r_cnt + c_one;
        end
    end
    assign o_period = r_period;
    assign o_bit    = r_bit;
    assign o_valid  = r_valid;
    assign o_lock   = r_lock;
endmodule

// File: tb/tb_fm_rx.sv
// tb_fm_rx: directed scoreboard bench for fm_rx, plus a 4-bit saturation instance
module tb_fm_rx;
    typedef struct {
        logic [15:0] p;
        logic        b;
    } exp_t;
    logic        clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic        i_fm = 1'b0;
    logic        i_clr = 1'b0;
    logic [15:0] i_thresh = 16'd12;
    logic [15:0] i_timeout = 16'd0;
    logic [15:0] o_period;
    logic        o_bit, o_valid, o_lock;
    logic        s_fm = 1'b0;
    logic [3:0]  s_period;
    logic        s_bit, s_valid, s_lock;
    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_r = 0;
    int          last_v = 0;
    int          s_cnt = 0;
    bit          have_prev = 0;
    bit          prev_v = 0;
    always #5 clk = ~clk;
    fm_rx u_dut (
        .i_clk     (clk),
        .i_nrst    (i_nrst),
        .i_fm      (i_fm),
        .i_thresh  (i_thresh),
        .i_timeout (i_timeout),
        .i_clr     (i_clr),
        .o_period  (o_period),
        .o_bit     (o_bit),
        .o_valid   (o_valid),
        .o_lock    (o_lock)
    );
    fm_rx #(.p_cnt_sz(4)) u_sat (
        .i_clk     (clk),
        .i_nrst    (i_nrst),
        .i_fm      (s_fm),
        .i_thresh  (4'd8),
        .i_timeout (4'd0),
        .i_clr     (1'b0),
        .o_period  (s_period),
        .o_bit     (s_bit),
        .o_valid   (s_valid),
        .o_lock    (s_lock)
    );
    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic tick(int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (o_valid) begin
                chk("valid_consecutive", 16'(prev_v), 16'd0);
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL unexpected_valid observed period=%0d expected no pulse", o_period);
                end else begin
                    e = q.pop_front();
                    chk("period", o_period, e.p);
                    chk("bit", 16'(o_bit), 16'(e.b));
                end
                last_v = cyc;
            end
            prev_v = o_valid;
            if (s_valid) begin
                chk("sat_period", 16'(s_period), 16'd15);
                chk("sat_bit", 16'(s_bit), 16'd0);
                s_cnt++;
            end
        end
    endtask
    task automatic rise();
        int d;
        d = cyc - last_r;
        if (have_prev) q.push_back('{p: (d > 65535) ? 16'hffff : 16'(d), b: d < int'(i_thresh)});
        have_prev = 1;
        last_r = cyc;
        i_fm = 1'b1;
    endtask
    task automatic stream(int n, int per);
        repeat (n) begin
            rise();
            tick(per / 2);
            i_fm = 1'b0;
            tick(per - per / 2);
        end
    endtask
    task automatic drain();
        for (int k = 0; k < 60 && q.size() > 0; k++) tick(1);
        chk("queue_drained", 16'(q.size()), 16'd0);
    endtask
    initial begin
        tick(3);
        chk("rst_period", o_period, 16'd0);
        chk("rst_bit", 16'(o_bit), 16'd0);
        chk("rst_valid", 16'(o_valid), 16'd0);
        chk("rst_lock", 16'(o_lock), 16'd0);
        i_nrst = 1'b1;
        tick(2);
        stream(6, 10);
        drain();
        chk("p10_lock", 16'(o_lock), 16'd1);
        chk("p10_bit", 16'(o_bit), 16'd1);
        stream(4, 20);
        chk("p20_bit", 16'(o_bit), 16'd0);
        chk("p20_period", o_period, 16'd20);
        stream(4, 10);
        drain();
        chk("switch_period", o_period, 16'd10);
        chk("switch_bit", 16'(o_bit), 16'd1);
        i_timeout = 16'd50;
        for (int k = 0; k < 200 && o_lock; k++) tick(1);
        chk("timeout_distance", 16'(cyc - last_v), 16'd50);
        chk("timeout_lock", 16'(o_lock), 16'd0);
        chk("timeout_hold", o_period, 16'd10);
        have_prev = 0;
        tick(20);
        stream(3, 10);
        i_fm = 1'b1;
        tick(3);
        i_clr = 1'b1;
        tick(1);
        i_clr = 1'b0;
        chk("clr_valid", 16'(o_valid), 16'd0);
        chk("clr_period", o_period, 16'd0);
        chk("clr_lock", 16'(o_lock), 16'd0);
        have_prev = 0;
        tick(1);
        i_fm = 1'b0;
        tick(5);
        stream(3, 10);
        drain();
        chk("after_clr_period", o_period, 16'd10);
        rise();
        tick(5);
        i_fm = 1'b0;
        tick(1);
        i_nrst = 1'b0;
        tick(1);
        i_nrst = 1'b1;
        chk("mrst_period", o_period, 16'd0);
        chk("mrst_bit", 16'(o_bit), 16'd0);
        chk("mrst_valid", 16'(o_valid), 16'd0);
        chk("mrst_lock", 16'(o_lock), 16'd0);
        have_prev = 0;
        tick(3);
        stream(3, 10);
        drain();
        chk("mrst_resume", o_period, 16'd10);
        repeat (3) begin
            s_fm = 1'b1;
            tick(20);
            s_fm = 1'b0;
            tick(20);
        end
        chk("sat_count", 16'(s_cnt), 16'd2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
